imem_fetch_port: RTL and testbench

Parametrised, synchronous instruction memory with a valid/ready fetch interface, a write-only program-load port and sticky halt detection. Sits between the program counter / fetch stage and decode in the simplified MIPS datapath. Replaces the fixed-size, combinationally read, constant-initialised instruction store. It lets programs be loaded at run time and lets fetch stall under back-pressure.

---
 rtl/imem_pkg.sv | 21 ++
 rtl/imem_array.sv | 38 +++
 rtl/imem_fetch_port.sv | 104 ++++++++++
 tb/tb_imem_fetch_port.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory fetch port.
package imem_pkg;

  localparam int          DATA_W_DEF    = 16;
  localparam int          ADDR_W_DEF    = 16;
  localparam int          DEPTH_DEF     = 1024;
  localparam logic [15:0] HALT_WORD_DEF = 16'hFFFF;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } imem_state_t;

  // Index width for a power-of-two depth.
  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

  localparam int IDX_W_DEF = idx_w(DEPTH_DEF);

endpackage

// File: rtl/imem_array.sv
// 1R/1W synchronous RAM. The read data is registered. The read samples the
// array before a same-edge write lands, so a read of the index being written
// returns the old word. The memory itself has no reset. Only the read
// register is cleared, so the response word reads 0 after reset.
module imem_array
  import imem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int IDX_W  = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rd_en,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Write port: program load.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_idx] <= i_wr_data;
  end

  // Read port: update only on an accepted fetch, so the word holds under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_idx];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction-memory fetch port. It has a valid/ready fetch path with a
// single-entry response register, a program-load write port, and a sticky
// halt that stops fetch after a halt word is consumed.
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DEPTH     = DEPTH_DEF,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_halt,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              clear_halt,
  output logic              halted
);

  localparam int IDX_W = idx_w(DEPTH);

  imem_state_t       r_state, w_state_nxt;
  logic              r_rsp_valid;
  logic [ADDR_W-1:0] r_rsp_addr;
  logic [DATA_W-1:0] w_rdata;
  logic              w_accept;
  logic              w_consume;
  logic              w_halt_consume;
  logic              w_unused;

  // Upper address bits are deliberately dropped, so addresses wrap modulo DEPTH.
  assign w_unused = ^{req_addr, ld_addr};

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rd_en   (w_accept),
    .i_rd_idx  (req_addr[IDX_W-1:0]),
    .o_rd_data (w_rdata),
    .i_wr_en   (ld_en),
    .i_wr_idx  (ld_addr[IDX_W-1:0]),
    .i_wr_data (ld_data)
  );

  // The halt flag is decoded from the registered word. It is gated by valid
  // so that it reads 0 after reset for any HALT_WORD encoding.
  assign rsp_halt       = r_rsp_valid && (w_rdata == HALT_WORD);
  assign w_consume      = r_rsp_valid && rsp_ready;
  assign w_halt_consume = w_consume && rsp_halt;

  // Ready depends only on state and the response handshake. The cycle that
  // consumes a halt word is already closed to new requests.
  assign req_ready = (r_state == RUN) && (!r_rsp_valid || (rsp_ready && !rsp_halt));
  assign w_accept  = req_valid && req_ready;

  // FSM next state: halt on consuming a halt word, resume on clear_halt.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_halt_consume) w_state_nxt = HALTED;
      HALTED:  if (clear_halt)     w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  // Response valid and address sideband. Both load on accept, and valid
  // clears when the response is consumed with nothing new behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_addr  <= req_addr;
    end else if (w_consume) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_instr = w_rdata;
  assign rsp_addr  = r_rsp_addr;
  assign halted    = (r_state == HALTED);

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed bench for imem_fetch_port. Inputs are driven 1ns after the rising
// edge, and outputs are checked 1ns later, away from the edge.
module tb_imem_fetch_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [15:0] req_addr;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_instr, rsp_addr;
  logic        rsp_halt;
  logic        ld_en;
  logic [15:0] ld_addr, ld_data;
  logic        clear_halt, halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_fetch_port dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_instr  (rsp_instr),
    .rsp_addr   (rsp_addr),
    .rsp_halt   (rsp_halt),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .clear_halt (clear_halt),
    .halted     (halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, to the drive point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; clear_halt = 1'b0;
    #12;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_instr", 32'(rsp_instr), 32'd0);
    check("rst_rsp_addr",  32'(rsp_addr),  32'd0);
    check("rst_rsp_halt",  32'(rsp_halt),  32'd0);
    check("rst_halted",    32'(halted),    32'd0);
    step();
    rst_n = 1'b1;
    #1 check("rst_req_ready", 32'(req_ready), 32'd1);

    // Program load.
    load(16'h0000, 16'h2009);
    load(16'h0001, 16'h200A);
    load(16'h0003, 16'h012B);
    load(16'h0005, 16'h012A);
    load(16'h0007, 16'h1111);
    load(16'h0008, 16'hFFFF);
    load(16'h0009, 16'h2222);

    // Back-to-back fetch of addresses 0 and 1.
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 16'h0000;
    #1 check("b2b_ready0", 32'(req_ready), 32'd1);
    step();
    req_addr = 16'h0001;
    #1;
    check("b2b_valid0", 32'(rsp_valid), 32'd1);
    check("b2b_instr0", 32'(rsp_instr), 32'h2009);
    check("b2b_addr0",  32'(rsp_addr),  32'h0000);
    check("b2b_ready1", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    #1;
    check("b2b_instr1", 32'(rsp_instr), 32'h200A);
    check("b2b_addr1",  32'(rsp_addr),  32'h0001);
    step();
    check("b2b_drain", 32'(rsp_valid), 32'd0);

    // Back-pressure: stall three cycles with a second request pending.
    req_valid = 1'b1; req_addr = 16'h0001; rsp_ready = 1'b0;
    step();
    req_addr = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_instr", 32'(rsp_instr), 32'h200A);
      check("bp_addr",  32'(rsp_addr),  32'h0001);
      check("bp_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    #1 check("bp_release_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    #1;
    check("bp_second_instr", 32'(rsp_instr), 32'h2009);
    check("bp_second_addr",  32'(rsp_addr),  32'h0000);
    step();

    // Address wrap on fetch and on load.
    req_valid = 1'b1; req_addr = 16'h0405;
    step();
    req_valid = 1'b0;
    #1;
    check("wrap_fetch_instr", 32'(rsp_instr), 32'h012A);
    check("wrap_fetch_addr",  32'(rsp_addr),  32'h0405);
    step();
    load(16'h0400, 16'hBEEF);
    req_valid = 1'b1; req_addr = 16'h0000;
    step();
    req_valid = 1'b0;
    #1 check("wrap_load_instr", 32'(rsp_instr), 32'hBEEF);
    step();
    load(16'h0000, 16'h2009);

    // Same-cycle fetch and load of the same index returns the old word.
    req_valid = 1'b1; req_addr = 16'h0003;
    ld_en = 1'b1; ld_addr = 16'h0003; ld_data = 16'h1234;
    step();
    ld_en = 1'b0; req_valid = 1'b0;
    #1 check("rbw_old", 32'(rsp_instr), 32'h012B);
    step();
    req_valid = 1'b1; req_addr = 16'h0003;
    step();
    req_valid = 1'b0;
    #1 check("rbw_new", 32'(rsp_instr), 32'h1234);
    step();

    // Halt: fetch 7, 8, 9 continuously; 8 holds the halt word.
    req_valid = 1'b1; req_addr = 16'h0007;
    step();
    req_addr = 16'h0008;
    #1;
    check("halt_instr7", 32'(rsp_instr), 32'h1111);
    check("halt_flag7",  32'(rsp_halt),  32'd0);
    step();
    req_addr = 16'h0009;
    #1;
    check("halt_instr8", 32'(rsp_instr), 32'hFFFF);
    check("halt_flag8",  32'(rsp_halt),  32'd1);
    check("halt_ready_on_consume", 32'(req_ready), 32'd0);
    check("halt_not_yet", 32'(halted), 32'd0);
    step();
    #1;
    check("halted_set",     32'(halted),    32'd1);
    check("halted_ready",   32'(req_ready), 32'd0);
    check("halted_novalid", 32'(rsp_valid), 32'd0);
    step();
    #1 check("halted_sticky", 32'(halted), 32'd1);
    clear_halt = 1'b1;
    step();
    clear_halt = 1'b0;
    #1;
    check("clear_halted", 32'(halted),    32'd0);
    check("clear_ready",  32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    #1;
    check("resume_instr9", 32'(rsp_instr), 32'h2222);
    check("resume_addr9",  32'(rsp_addr),  32'h0009);
    step();

    // Reset during a stall drops the response but keeps memory.
    req_valid = 1'b1; req_addr = 16'h0001; rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    #1 check("mid_stall_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",  32'(rsp_valid), 32'd0);
    check("mid_rst_halted", 32'(halted),    32'd0);
    check("mid_rst_instr",  32'(rsp_instr), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    req_valid = 1'b1; req_addr = 16'h0000; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    #1 check("post_rst_mem", 32'(rsp_instr), 32'h2009);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
